// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the RV32I execute stage and a byte-addressed, word-wide data
//   memory. Loads (LB/LH/LW/LBU/LHU) become one aligned word read followed by
//   lane extraction and sign/zero extension. SW is a single word write. SB/SH
//   are read-modify-write: the word is read, the addressed lanes are replaced,
//   and the merged word is written back. Misaligned, out-of-range and illegal
//   funct3 requests skip the memory entirely and respond with an error.
//
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   req_valid    core presents a request; accepted when req_ready is high
//   req_ready    high only while idle
//   req_write    1 = store, 0 = load
//   req_funct3   RV32I funct3 selecting access width and extension
//   req_addr     byte address
//   req_wdata    store data (low byte/halfword used for SB/SH)
//   resp_valid   one-cycle completion pulse
//   resp_rdata   extended load data; 0 for stores and errors
//   resp_err     misaligned / out-of-range / illegal funct3, valid with resp_valid
//   mem_address  word-aligned address, held until the next acceptance
//   mem_read     read enable (memory read data is combinational)
//   mem_write    write enable (memory commits the word at the next rising edge)
//   mem_wdata    full word to write
//   mem_rdata    memory read data

module load_store_unit #(
    parameter int unsigned   AW   = 32,
    parameter int unsigned   DW   = 32,
    parameter logic [AW-1:0] BASE = 'h1000,
    parameter int unsigned   SIZE = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_address,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]    state;

    // Request fields latched at acceptance
    logic [AW-1:0] addr_q;
    logic [2:0]    funct3_q;
    logic          write_q;
    logic [15:0]   wdata_q;
    logic [1:0]    off_q;

    // ------------------------------------------------------------------
    // Request checks (evaluated on the live request while idle)
    // ------------------------------------------------------------------
    logic [1:0]    req_off;
    logic [AW-1:0] req_aligned;
    logic [AW:0]   span_lo;
    logic [AW:0]   span_hi;
    logic [AW:0]   mem_lo;
    logic [AW:0]   mem_hi;
    logic          misaligned;
    logic          out_of_range;
    logic          illegal_f3;
    logic          req_err;
    logic          req_is_sw;

    assign req_off     = req_addr[1:0];
    assign req_aligned = {req_addr[AW-1:2], 2'b00};

    // One extra bit so the top word of the address space cannot wrap
    assign span_lo = {1'b0, req_aligned};
    assign span_hi = span_lo + (AW+1)'(3);
    assign mem_lo  = {1'b0, BASE};
    assign mem_hi  = mem_lo + (AW+1)'(SIZE) - (AW+1)'(1);

    assign out_of_range = (span_lo < mem_lo) || (span_hi > mem_hi);

    always_comb begin
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = req_off[0];
            2'b10:   misaligned = (req_off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        if (req_write)
            illegal_f3 = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        else
            illegal_f3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end

    assign req_err   = misaligned || out_of_range || illegal_f3;
    assign req_is_sw = req_write && (req_funct3[1:0] == 2'b10);

    // ------------------------------------------------------------------
    // Lane extraction for loads and lane merge for SB/SH
    // ------------------------------------------------------------------
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [DW-1:0] load_data;
    logic [DW-1:0] merged;

    assign off_q  = addr_q[1:0];
    assign lane_b = mem_rdata[{off_q, 3'b000} +: 8];
    assign lane_h = mem_rdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_data = {24'h000000, lane_b};
            3'b101:  load_data = {16'h0000, lane_h};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (funct3_q[0])
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
        else
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            funct3_q   <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        funct3_q   <= req_funct3;
                        write_q    <= req_write;
                        wdata_q    <= req_wdata[15:0];
                        resp_rdata <= '0;
                        resp_err   <= req_err;
                        if (req_err) begin
                            state <= S_RESP;
                        end else if (req_is_sw) begin
                            mem_wdata <= req_wdata;
                            state     <= S_WR;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (write_q) begin
                        mem_wdata <= merged;
                        state     <= S_WR;
                    end else begin
                        resp_rdata <= load_data;
                        state      <= S_RESP;
                    end
                end
                S_WR:    state <= S_RESP;
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state register so that reset removes
    // mem_write without waiting for a clock edge.
    assign req_ready   = (state == S_IDLE);
    assign mem_read    = (state == S_RD);
    assign mem_write   = (state == S_WR);
    assign resp_valid  = (state == S_RESP);
    assign mem_address = {addr_q[AW-1:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    load_store_unit #(
        .AW   (32),
        .DW   (32),
        .BASE (32'h1000),
        .SIZE (1024)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: 256 words at 0x1000..0x13FF, combinational read
    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_address[9:2]];
    always @(posedge clk) begin
        if (mem_write)
            mem[mem_address[9:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Strobe invariants, every cycle
    always @(negedge clk) begin
        check("rd_wr_excl", {31'b0, mem_read & mem_write}, 32'd0);
        check("idle_quiet", {31'b0, req_ready & (mem_read | mem_write | resp_valid)}, 32'd0);
    end

    // One request through the DUT, then compare its response, latency,
    // read/write cycle counts and (for stores) the written word.
    task automatic op(input string tag, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input int exp_nrd, input int exp_nwr,
                      input logic [31:0] exp_w);
        int n;
        int lat;
        int nrd;
        int nwr;
        logic [31:0] wword;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat = 1; nrd = 0; nwr = 0; wword = '0;
        while (!resp_valid && lat < 10) begin
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                wword = mem_wdata;
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"},   lat, exp_lat);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"},   {31'b0, resp_err}, {31'b0, exp_err});
        check({tag, "_nrd"},   nrd, exp_nrd);
        check({tag, "_nwr"},   nwr, exp_nwr);
        if (exp_nwr > 0)
            check({tag, "_wword"}, wword, exp_w);
    endtask

    logic [2:0]  bb_f3   [4];
    logic [31:0] bb_addr [4];
    logic [31:0] bb_exp  [4];
    int          acc_cyc [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc;
        int nresp;
        logic accepted;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;

        #2;
        check("rst_ready",  {31'b0, req_ready},  32'd1);
        check("rst_rvalid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata",  resp_rdata,          32'd0);
        check("rst_err",    {31'b0, resp_err},   32'd0);
        check("rst_mrd",    {31'b0, mem_read},   32'd0);
        check("rst_mwr",    {31'b0, mem_write},  32'd0);
        check("rst_maddr",  mem_address,         32'd0);
        check("rst_mwdata", mem_wdata,           32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Loads from 0x80F0_7F01 at 0x1004
        op("sw_init",  1, 3'b010, 32'h1004, 32'h80F07F01, 32'h0, 0, 2, 0, 1, 32'h80F07F01);
        op("lb",       0, 3'b000, 32'h1006, 32'h0, 32'hFFFFFFF0, 0, 2, 1, 0, 32'h0);
        op("lbu",      0, 3'b100, 32'h1006, 32'h0, 32'h000000F0, 0, 2, 1, 0, 32'h0);
        op("lh",       0, 3'b001, 32'h1006, 32'h0, 32'hFFFF80F0, 0, 2, 1, 0, 32'h0);
        op("lw",       0, 3'b010, 32'h1004, 32'h0, 32'h80F07F01, 0, 2, 1, 0, 32'h0);

        // SB read-modify-write
        op("sw_sbw",   1, 3'b010, 32'h1004, 32'h11223344, 32'h0, 0, 2, 0, 1, 32'h11223344);
        op("sb",       1, 3'b000, 32'h1005, 32'h000000AA, 32'h0, 0, 3, 1, 1, 32'h1122AA44);
        op("lw_sb",    0, 3'b010, 32'h1004, 32'h0, 32'h1122AA44, 0, 2, 1, 0, 32'h0);

        // SH upper half; upper bits of wdata must be ignored
        op("sw_shw",   1, 3'b010, 32'h1008, 32'h00000000, 32'h0, 0, 2, 0, 1, 32'h00000000);
        op("sh",       1, 3'b001, 32'h100A, 32'h1234BEEF, 32'h0, 0, 3, 1, 1, 32'hBEEF0000);
        op("lhu",      0, 3'b101, 32'h100A, 32'h0, 32'h0000BEEF, 0, 2, 1, 0, 32'h0);
        op("lh_neg",   0, 3'b001, 32'h100A, 32'h0, 32'hFFFFBEEF, 0, 2, 1, 0, 32'h0);

        // SW and the last valid word
        op("sw",       1, 3'b010, 32'h100C, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1, 32'hDEADBEEF);
        op("lw_sw",    0, 3'b010, 32'h100C, 32'h0, 32'hDEADBEEF, 0, 2, 1, 0, 32'h0);
        op("sw_last",  1, 3'b010, 32'h13FC, 32'hCAFEF00D, 32'h0, 0, 2, 0, 1, 32'hCAFEF00D);
        op("lw_last",  0, 3'b010, 32'h13FC, 32'h0, 32'hCAFEF00D, 0, 2, 1, 0, 32'h0);
        op("lb_last",  0, 3'b000, 32'h13FF, 32'h0, 32'hFFFFFFCA, 0, 2, 1, 0, 32'h0);

        // Error paths
        op("e_lw_mis", 0, 3'b010, 32'h1002, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0);
        op("e_sh_mis", 1, 3'b001, 32'h1001, 32'hFFFF, 32'h0, 1, 1, 0, 0, 32'h0);
        op("e_lo",     0, 3'b010, 32'h0FFC, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0);
        op("e_hi",     0, 3'b010, 32'h1400, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0);
        op("e_ld_f3",  0, 3'b011, 32'h1004, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0);
        op("e_st_f3",  1, 3'b011, 32'h1004, 32'h1, 32'h0, 1, 1, 0, 0, 32'h0);
        check("err_mem_kept", mem[1], 32'h1122AA44);

        // Reset during the WR cycle of an SB
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h100C; req_wdata = 32'h00000055;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstwr_rd", {31'b0, mem_read}, 32'd1);
        @(negedge clk);
        check("rstwr_wr", {31'b0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstwr_mwr",    {31'b0, mem_write},  32'd0);
        check("rstwr_mrd",    {31'b0, mem_read},   32'd0);
        check("rstwr_rvalid", {31'b0, resp_valid}, 32'd0);
        check("rstwr_rdata",  resp_rdata,          32'd0);
        check("rstwr_maddr",  mem_address,         32'd0);
        check("rstwr_mwdata", mem_wdata,           32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstwr_ready", {31'b0, req_ready}, 32'd1);
        check("rstwr_mem",   mem[3], 32'hDEADBEEF);
        op("lw_rstwr", 0, 3'b010, 32'h100C, 32'h0, 32'hDEADBEEF, 0, 2, 1, 0, 32'h0);

        // Back-to-back loads with req_valid held high
        bb_f3[0] = 3'b010; bb_addr[0] = 32'h1004; bb_exp[0] = 32'h1122AA44;
        bb_f3[1] = 3'b101; bb_addr[1] = 32'h100A; bb_exp[1] = 32'h0000BEEF;
        bb_f3[2] = 3'b000; bb_addr[2] = 32'h100C; bb_exp[2] = 32'hFFFFFFEF;
        bb_f3[3] = 3'b010; bb_addr[3] = 32'h13FC; bb_exp[3] = 32'hCAFEF00D;
        nacc = 0; nresp = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0;
        req_funct3 = bb_f3[0]; req_addr = bb_addr[0]; req_wdata = '0;
        for (int c = 0; c < 40 && nresp < 4; c++) begin
            if (resp_valid) begin
                check("b2b_rdata", resp_rdata, bb_exp[nresp]);
                nresp++;
            end
            accepted = 1'b0;
            if (req_ready && req_valid) begin
                acc_cyc[nacc] = c;
                nacc++;
                accepted = 1'b1;
            end
            @(negedge clk);
            if (accepted) begin
                if (nacc < 4) begin
                    req_funct3 = bb_f3[nacc];
                    req_addr   = bb_addr[nacc];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        check("b2b_nacc",  nacc,  32'd4);
        check("b2b_nresp", nresp, 32'd4);
        for (int i = 1; i < 4; i++)
            check("b2b_gap", acc_cyc[i] - acc_cyc[i-1], 32'd3);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the RV32I core's execute stage and the byte-addressed word data memory.
- Turns LB/LH/LW/LBU/LHU/SB/SH/SW requests into aligned 32-bit memory reads and writes, little-endian.
- Loads: extracts the addressed byte/halfword/word and zero- or sign-extends it.
- SB/SH: the memory writes all four bytes, so the block does a read-modify-write to merge the new bytes into the existing word.
- Checks alignment and address range, and reports a one-cycle response with an error flag.

Parameters:
- AW, 32: address width.
- DW, 32: data width (fixed at 32).
- BASE, 'h1000: lowest valid byte address of data memory.
- SIZE, 1024: data memory size in bytes.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid & req_ready at a rising edge.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- req_addr  input  AW  byte address.
- req_wdata  input  DW  store data; low bytes are used for SB/SH.
- resp_valid  output  1  one-cycle pulse when the operation completes.
- resp_rdata  output  DW  extended load data; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid: misaligned, out-of-range or illegal funct3.
- mem_address  output  AW  word-aligned address {addr[AW-1:2],2'b00}.
- mem_read  output  1  memory read enable (memory read is combinational).
- mem_write  output  1  memory write enable (memory writes 4 bytes at the next rising edge).
- mem_wdata  output  DW  full word to write.
- mem_rdata  input  DW  memory read data.

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - Cleared to 0: resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_address, mem_wdata, and the internal address/data/funct3 registers.
  - mem_write drops immediately, so an in-flight op aborted by reset never writes memory.
- States: IDLE, RD, WR, RESP.
- Acceptance: at edge E the block latches addr, funct3, write, wdata, and byte offset off=addr[1:0]. The next state is chosen as follows.
  - Error: next state RESP, with err=1.
    - Misaligned: LH/LHU/SH with off[0]=1, or LW/SW with off!=0.
    - Out of range: aligned addr < BASE, or aligned addr+3 > BASE+SIZE-1.
    - Illegal funct3: load funct3 of 011/110/111, or store funct3 > 010.
  - Load: RD.
  - SW: WR, with mem_wdata=req_wdata.
  - SB/SH: RD.
- RD (one cycle): mem_read=1, mem_write=0.
  - Load: at the next edge capture the lane and extend it into resp_rdata, then go to RESP.
    - Byte lane k = mem_rdata[8k+7:8k].
    - LB/LH sign-extend; LBU/LHU zero-extend.
    - LW passes the word through.
  - SB: at the next edge mem_wdata = mem_rdata with lane off replaced by wdata[7:0], then go to WR.
  - SH: at the next edge mem_wdata = mem_rdata with lanes off and off+1 replaced by wdata[15:0], then go to WR.
- WR (one cycle): mem_write=1, mem_read=0; the memory commits at the next edge; then go to RESP.
- RESP (one cycle): resp_valid=1, req_ready=0, mem_read=mem_write=0; then go to IDLE.
  - resp_err=0 except on the error path.
  - resp_rdata=0 for stores and errors.
- Latency from the accepting edge E to the resp_valid cycle:
  - Load: RESP follows E+1 (3-cycle throughput).
  - SW: RESP follows E+1.
  - SB/SH: RESP follows E+2.
  - Error: RESP follows E.
- Invariants:
  - mem_read and mem_write are never both 1.
  - Neither is 1 in IDLE or RESP.
  - req_ready=1 only in IDLE.
  - Inputs outside IDLE are ignored; request fields need not be held after acceptance.
- mem_address holds the latched aligned address from acceptance until the next acceptance.
- Boundary cases:
  - Last valid word BASE+SIZE-4 is accepted; BASE+SIZE returns err.
  - req_valid held high in RESP is accepted only at the IDLE edge that follows.

Test Plan:
- Memory word at 0x1004 = 0x80F0_7F01:
  - LB 0x1006 -> resp_rdata 0xFFFF_FFF0.
  - LBU 0x1006 -> 0x0000_00F0.
  - LH 0x1006 -> 0xFFFF_80F0.
  - LW 0x1004 -> 0x80F0_7F01.
  - Each load: resp_err=0, resp_valid 2 cycles after acceptance.
- SB 0x1005 with req_wdata=0x0000_00AA on word 0x1122_3344 -> one RD cycle, then WR with mem_wdata=0x1122_AA44; a subsequent LW returns 0x1122_AA44.
- SH 0x100A with wdata=0xBEEF on word 0x0 -> mem_wdata=0xBEEF_0000; SW 0x100C 0xDEAD_BEEF -> no mem_read cycle, one mem_write cycle.
- Errors: LW 0x1002, SH 0x1001, LW 0x0FFC, LW 0x1400 (SIZE=1024), load funct3=011 -> each gives resp_valid with resp_err=1, resp_rdata=0, and no mem_read/mem_write.
- Assert rst_n=0 during the WR cycle of an SB -> mem_write falls immediately, memory is unchanged, outputs are 0, and req_ready=1 after release.
- Back-to-back req_valid held high with 4 loads -> req_ready pulses once every 3 cycles and each response matches its own address.
